// File: rtl/vend_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : vend_pkg                                               |
// | Brief   : Shared types and constants for the vending controller: |
// |           FSM state encodings, coin values, default prices and   |
// |           the coin-pulse to BCD conversion helper.               |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package vend_pkg;

   typedef enum logic [1:0] {
      ST_DONE = 2'b00,
      ST_IDLE = 2'b01,
      ST_PAY  = 2'b10,
      ST_VEND = 2'b11
   } vend_state_e;

   localparam logic [3:0]  C_COIN_1  = 4'd1;
   localparam logic [3:0]  C_COIN_5  = 4'd5;
   localparam logic [3:0]  C_COIN_10 = 4'd10;

   localparam logic [7:0]  C_DEF_PRICE0 = 8'h15;
   localparam logic [7:0]  C_DEF_PRICE1 = 8'h25;
   localparam logic [7:0]  C_DEF_PRICE2 = 8'h50;
   localparam logic [7:0]  C_DEF_PRICE3 = 8'h99;

   localparam logic [31:0] C_DEF_HOLD_CYCLES    = 32'd100_000_000;
   localparam logic [31:0] C_DEF_TIMEOUT_CYCLES = 32'd500_000_000;

   // Sum of the coins pulsed in one cycle (0..16) as a 3-digit BCD value.
   function automatic logic [11:0] coin_sum_bcd(input logic c1, input logic c5, input logic c10);
      logic [4:0] s;
      logic [4:0] r;
      s = (c1  ? {1'b0, C_COIN_1}  : 5'd0)
        + (c5  ? {1'b0, C_COIN_5}  : 5'd0)
        + (c10 ? {1'b0, C_COIN_10} : 5'd0);
      r = s - 5'd10;
      if (s >= 5'd10) coin_sum_bcd = {4'h0, 4'h1, r[3:0]};
      else            coin_sum_bcd = {4'h0, 4'h0, s[3:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_addsub.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : bcd_addsub                                              |
// | Brief  : 3-digit packed BCD adder/subtractor. co_o is the carry  |
// |          out of the hundreds digit on add (result > 999) and the |
// |          borrow out on subtract (a_i < b_i).                     |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module bcd_addsub (
   input  logic [11:0] a_i,
   input  logic [11:0] b_i,
   input  logic        sub_i,
   output logic [11:0] y_o,
   output logic        co_o
);

   // Ripple digit by digit, correcting each nibble back into 0..9.
   always_comb begin
      logic [4:0] t;
      logic       c;
      t   = 5'd0;
      c   = 1'b0;
      y_o = 12'h000;
      for (int k = 0; k < 3; k++) begin
         if (sub_i) begin
            // a-b-c lies in -10..9; bit 4 flags a negative digit result
            t = {1'b0, a_i[4*k +: 4]} - {1'b0, b_i[4*k +: 4]} - {4'b0000, c};
            if (t[4]) begin
               t = t + 5'd10;
               c = 1'b1;
            end else begin
               c = 1'b0;
            end
         end else begin
            t = {1'b0, a_i[4*k +: 4]} + {1'b0, b_i[4*k +: 4]} + {4'b0000, c};
            if (t > 5'd9) begin
               t = t - 5'd10;
               c = 1'b1;
            end else begin
               c = 1'b0;
            end
         end
         y_o[4*k +: 4] = t[3:0];
      end
      co_o = c;
   end

endmodule
`default_nettype wire

// File: rtl/vend_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : vend_ctrl                                               |
// | Brief  : Four-item vending controller. Select an item, insert    |
// |          coins (BCD money up to 999), confirm to vend with       |
// |          change or cancel for a refund. All outputs registered.  |
// | Config : define VEND_TIMEOUT_EN to refund automatically after    |
// |          TIMEOUT_CYCLES without customer activity in PAY.        |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module vend_ctrl
   import vend_pkg::*;
#(
   parameter logic [7:0]  PRICE0         = C_DEF_PRICE0,
   parameter logic [7:0]  PRICE1         = C_DEF_PRICE1,
   parameter logic [7:0]  PRICE2         = C_DEF_PRICE2,
   parameter logic [7:0]  PRICE3         = C_DEF_PRICE3,
   parameter logic [31:0] HOLD_CYCLES    = C_DEF_HOLD_CYCLES,
   parameter logic [31:0] TIMEOUT_CYCLES = C_DEF_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        coin_1,
   input  logic        coin_5,
   input  logic        coin_10,
   input  logic        sel_vld,
   input  logic [1:0]  sel,
   input  logic        confirm,
   input  logic        cancel,
   output logic [7:0]  goods_money,
   output logic [11:0] money,
   output logic [11:0] small_change,
   output logic [1:0]  state,
   output logic        dispense,
   output logic [1:0]  goods_id,
   output logic        coin_reject,
   output logic        short_pay
);

   vend_state_e state_q;
   logic [7:0]  goods_money_q;
   logic [11:0] money_q;
   logic [11:0] small_change_q;
   logic        dispense_q;
   logic [1:0]  goods_id_q;
   logic        coin_reject_q;
   logic        short_pay_q;
   logic [1:0]  sel_idx_q;
   logic [31:0] hold_cnt_q;

   logic [11:0] w_coin_bcd;
   logic        w_any_coin;
   logic [11:0] w_money_sum;
   logic        w_money_ovf;
   logic [11:0] w_change;
   logic        w_short;
   logic        w_timeout;
   logic        w_cancel;

   function automatic logic [7:0] price_of(input logic [1:0] idx);
      case (idx)
         2'd0:    price_of = PRICE0;
         2'd1:    price_of = PRICE1;
         2'd2:    price_of = PRICE2;
         default: price_of = PRICE3;
      endcase
   endfunction

   assign w_coin_bcd = coin_sum_bcd(coin_1, coin_5, coin_10);
   assign w_any_coin = coin_1 | coin_5 | coin_10;

   // Running total plus this cycle's coins; carry out means the total would pass 999.
   bcd_addsub u_coin_add (
      .a_i   (money_q),
      .b_i   (w_coin_bcd),
      .sub_i (1'b0),
      .y_o   (w_money_sum),
      .co_o  (w_money_ovf)
   );

   // Money minus price: borrow is the short-pay compare, the difference is the change.
   bcd_addsub u_change_sub (
      .a_i   (money_q),
      .b_i   ({4'h0, goods_money_q}),
      .sub_i (1'b1),
      .y_o   (w_change),
      .co_o  (w_short)
   );

`ifdef VEND_TIMEOUT_EN
   logic [31:0] to_cnt_q;
   logic        w_activity;

   assign w_activity = w_any_coin | sel_vld | confirm;
   assign w_timeout  = (state_q == ST_PAY) && !w_activity
                       && (to_cnt_q == TIMEOUT_CYCLES - 32'd1);

   // Idle-cycle counter in PAY; any customer input restarts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         to_cnt_q <= 32'd0;
      else if ((state_q != ST_PAY) || w_activity || w_timeout)
         to_cnt_q <= 32'd0;
      else
         to_cnt_q <= to_cnt_q + 32'd1;
   end
`else
   localparam logic [31:0] c_unused_timeout = TIMEOUT_CYCLES;
   assign w_timeout = 1'b0;
`endif

   assign w_cancel = cancel | w_timeout;

   // Main transaction FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         goods_money_q  <= 8'h00;
         money_q        <= 12'h000;
         small_change_q <= 12'h000;
         dispense_q     <= 1'b0;
         goods_id_q     <= 2'd0;
         coin_reject_q  <= 1'b0;
         short_pay_q    <= 1'b0;
         sel_idx_q      <= 2'd0;
         hold_cnt_q     <= 32'd0;
      end else begin
         dispense_q    <= 1'b0;
         coin_reject_q <= 1'b0;
         short_pay_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // no item chosen yet, so coins are handed back
               if (w_any_coin) coin_reject_q <= 1'b1;
               if (sel_vld) begin
                  goods_money_q <= price_of(sel);
                  sel_idx_q     <= sel;
                  state_q       <= ST_PAY;
               end
            end
            ST_PAY: begin
               if (w_cancel) begin
                  // refund wins over everything; coins this cycle are returned
                  if (w_any_coin) coin_reject_q <= 1'b1;
                  small_change_q <= money_q;
                  hold_cnt_q     <= 32'd0;
                  state_q        <= ST_DONE;
               end else begin
                  if (w_any_coin) begin
                     if (w_money_ovf) coin_reject_q <= 1'b1;
                     else             money_q       <= w_money_sum;
                  end
                  // confirm judges the pre-coin total, so coins arriving
                  // alongside it can only increase the change
                  if (confirm) begin
                     if (w_short) begin
                        short_pay_q <= 1'b1;
                     end else begin
                        dispense_q <= 1'b1;
                        goods_id_q <= sel_idx_q;
                        state_q    <= ST_VEND;
                     end
                  end else if (sel_vld) begin
                     goods_money_q <= price_of(sel);
                     sel_idx_q     <= sel;
                  end
               end
            end
            ST_VEND: begin
               if (w_any_coin) coin_reject_q <= 1'b1;
               small_change_q <= w_change;
               hold_cnt_q     <= 32'd0;
               state_q        <= ST_DONE;
            end
            default: begin
               if (w_any_coin) coin_reject_q <= 1'b1;
               if (sel_vld) begin
                  money_q        <= 12'h000;
                  small_change_q <= 12'h000;
                  goods_money_q  <= price_of(sel);
                  sel_idx_q      <= sel;
                  hold_cnt_q     <= 32'd0;
                  state_q        <= ST_PAY;
               end else if (hold_cnt_q == HOLD_CYCLES - 32'd1) begin
                  money_q        <= 12'h000;
                  small_change_q <= 12'h000;
                  goods_money_q  <= 8'h00;
                  hold_cnt_q     <= 32'd0;
                  state_q        <= ST_IDLE;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 32'd1;
               end
            end
         endcase
      end
   end

   assign state        = state_q;
   assign goods_money  = goods_money_q;
   assign money        = money_q;
   assign small_change = small_change_q;
   assign dispense     = dispense_q;
   assign goods_id     = goods_id_q;
   assign coin_reject  = coin_reject_q;
   assign short_pay    = short_pay_q;

endmodule
`default_nettype wire
